// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, register codes and decoded-word types for decode_stage.
// DECODE_ILLEGAL_TRAP_EN selects whether illegal words are presented or dropped.
package decode_pkg;

  localparam logic [2:0] OPC_ADD = 3'b000;
  localparam logic [2:0] OPC_SUB = 3'b001;
  localparam logic [2:0] OPC_MUL = 3'b010;
  localparam logic [2:0] OPC_DIV = 3'b011;
  localparam logic [2:0] OPC_LDA = 3'b100;
  localparam logic [2:0] OPC_STA = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ILL = 3'b111;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_LDA = 3'd4,
    OP_STA = 3'd5,
    OP_MOV = 3'd6,
    OP_NOP = 3'd7
  } dec_op_t;

  localparam logic [31:0] REG_B = 32'h0000_000B;
  localparam logic [31:0] REG_C = 32'h0000_000C;

  localparam logic [1:0] RSEL_NONE = 2'b00;
  localparam logic [1:0] RSEL_B    = 2'b01;
  localparam logic [1:0] RSEL_C    = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    dec_op_t     op;
    logic        addr_mode;
    logic [1:0]  reg_sel;
    logic [31:0] operand;
  } dec_fields_t;

  typedef struct packed {
    logic        illegal;
    dec_fields_t f;
  } dec_word_t;

  localparam dec_fields_t FIELDS_RST = '{
    op:        OP_NOP,
    addr_mode: 1'b0,
    reg_sel:   RSEL_NONE,
    operand:   32'h0
  };

  // RSEL_NONE doubles as "not a register" for the legality check
  function automatic logic [1:0] reg_code(input logic [31:0] i_f);
    logic [1:0] v;
    if (i_f == REG_B)
      v = RSEL_B;
    else if (i_f == REG_C)
      v = RSEL_C;
    else
      v = RSEL_NONE;
    return v;
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: combinational map from the 68-bit fetch word
// to the decoded struct, including the legality check.
module inst_decoder
  import decode_pkg::*;
(
  input  logic [67:0] i_inst,
  output dec_word_t   o_dec
);

  logic [2:0]  w_opc;
  logic        w_mode;
  logic [31:0] w_dst;
  logic [31:0] w_opd;
  logic [1:0]  w_rsel;
  logic        w_ill;
  dec_op_t     w_op;

  assign w_opc  = i_inst[67:65];
  assign w_mode = i_inst[64];
  assign w_dst  = i_inst[63:32];
  assign w_opd  = i_inst[31:0];

  always_comb begin
    w_op   = OP_NOP;
    w_rsel = RSEL_NONE;
    w_ill  = 1'b0;
    unique case (w_opc)
      OPC_ADD, OPC_SUB, OPC_MUL, OPC_DIV: begin
        w_op = dec_op_t'(w_opc);
        if (!w_mode) begin
          w_rsel = reg_code(w_opd);
          w_ill  = (w_rsel == RSEL_NONE);
        end
      end
      OPC_LDA: w_op = OP_LDA;
      OPC_STA: w_op = OP_STA;
      OPC_MOV: begin
        w_op   = OP_MOV;
        w_rsel = reg_code(w_dst);
        w_ill  = (w_rsel == RSEL_NONE);
      end
      OPC_ILL: w_ill = 1'b1;
      default: w_ill = 1'b1;
    endcase
  end

  assign o_dec.illegal     = w_ill;
  assign o_dec.f.op        = w_ill ? OP_NOP : w_op;
  assign o_dec.f.reg_sel   = w_ill ? RSEL_NONE : w_rsel;
  assign o_dec.f.addr_mode = w_mode;
  assign o_dec.f.operand   = w_opd;

endmodule

// File: rtl/decode_stage.sv
// decode_stage: 2-entry skid buffer around inst_decoder, latency 1.
// DECODE_ILLEGAL_TRAP_EN: present illegal words as NOP + dec_illegal.
module decode_stage
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [67:0] fetch_inst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic        dec_ready,
  input  logic        dec_flush,
  output logic        dec_valid,
  output logic [2:0]  dec_op,
  output logic        dec_addr_mode,
  output logic [1:0]  dec_reg,
  output logic [31:0] dec_operand,
  output logic        dec_illegal
);

  occ_t        r_state;
  logic        r_valid;
  logic        r_ready;
  dec_fields_t r_head;
  dec_fields_t r_skid;

  dec_word_t   w_dec;
  logic        w_acc;
  logic        w_keep;
  logic        w_in;
  logic        w_out;
  logic        w_ld_head;
  logic        w_ld_skid;
  logic        w_pop_skid;

  inst_decoder u_dec (
    .i_inst (fetch_inst),
    .o_dec  (w_dec)
  );

  assign w_acc = fetch_valid & r_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign w_keep = 1'b1;
`else
  // illegal words complete the handshake but never enter the buffer
  assign w_keep = ~w_dec.illegal;
`endif

  assign w_in  = w_acc & w_keep;
  assign w_out = r_valid & dec_ready;

  assign w_ld_head = ~dec_flush & w_in &
    ((r_state == ST_EMPTY) | ((r_state == ST_ONE) & w_out));
  assign w_ld_skid = ~dec_flush & w_in &
    (r_state == ST_ONE) & ~w_out;
  assign w_pop_skid = ~dec_flush & w_out &
    (r_state == ST_TWO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else if (dec_flush) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_in) begin
          r_state <= ST_ONE;
          r_valid <= 1'b1;
        end
        ST_ONE: if (w_in && !w_out) begin
          r_state <= ST_TWO;
          r_ready <= 1'b0;
        end else if (!w_in && w_out) begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
        end
        ST_TWO: if (w_out) begin
          r_state <= ST_ONE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= FIELDS_RST;
      r_skid <= FIELDS_RST;
    end else begin
      if (w_ld_head)
        r_head <= w_dec.f;
      else if (w_pop_skid)
        r_head <= r_skid;
      if (w_ld_skid)
        r_skid <= w_dec.f;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_head_ill;
  logic r_skid_ill;
  logic r_trap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_ill <= 1'b0;
      r_skid_ill <= 1'b0;
      r_trap     <= 1'b0;
    end else begin
      if (w_ld_head)
        r_head_ill <= w_dec.illegal;
      else if (w_pop_skid)
        r_head_ill <= r_skid_ill;
      if (w_ld_skid)
        r_skid_ill <= w_dec.illegal;
      if (w_in && w_dec.illegal && !dec_flush)
        r_trap <= 1'b1;
    end
  end

  // sticky trap is always set by the time an illegal head is shown
  assign dec_illegal = r_head_ill & r_trap;
`else
  assign dec_illegal = 1'b0;
`endif

  assign fetch_ready   = r_ready;
  assign dec_valid     = r_valid;
  assign dec_op        = r_head.op;
  assign dec_addr_mode = r_head.addr_mode;
  assign dec_reg       = r_head.reg_sel;
  assign dec_operand   = r_head.operand;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high; clears all state immediately, released synchronously by the environment.
REQ-003 SHALL: fetch_inst  in  68  fetch-stage word: [67:65] opcode, [64] addressing mode, [63:32] destination field, [31:0] operand field.
REQ-004 SHALL: fetch_valid  in  1  fetch_inst is valid this cycle.
REQ-005 SHALL: fetch_ready  out  1  decode can accept a word; driven directly from a flop.
REQ-006 SHALL: dec_ready  in  1  downstream (execute) accepts the presented word this cycle.
REQ-007 SHALL: dec_flush  in  1  synchronous discard of all buffered words.
REQ-008 SHALL: dec_valid  out  1  decoded word presented.
REQ-009 SHALL: dec_op  out  3  opcode class (ADD, SUB, MUL, DIV, LDA, STA, MOV, NOP).
REQ-010 SHALL: dec_addr_mode  out  1  1 = address operand, 0 = data/register operand.
REQ-011 SHALL: dec_reg  out  2  register select: 01 = B (0xB), 10 = C (0xC), 00 = none.
REQ-012 SHALL: dec_operand  out  32  operand field [31:0], passed unmodified.
REQ-013 SHALL: dec_illegal  out  1  presented word failed decode (trap build only).

Function
REQ-014 SHALL: transfer occurs when fetch_valid && fetch_ready; output transfer when dec_valid && dec_ready.
REQ-015 SHALL: 2-entry skid buffer, occupancy FSM EMPTY -> ONE -> TWO; an accepted word appears on dec_valid the cycle after acceptance (latency 1).
REQ-016 SHALL: FSM transitions: EMPTY+in -> ONE; ONE+in+out -> ONE; ONE+in only -> TWO; ONE+out only -> EMPTY; TWO+out -> ONE; TWO never accepts.
REQ-017 SHALL: fetch_ready = 0 exactly when next state is TWO; words are presented strictly in arrival order; no word lost or duplicated.
REQ-018 SHALL: decode: opcodes 000-101 map to ADD/SUB/MUL/DIV/LDA/STA; 110 = MOV; 111 = illegal.
REQ-019 SHALL: dec_reg: ALU ops with mode 0 take register from [31:0]; MOV takes register from [63:32]; LDA/STA yield 00.
REQ-020 SHALL: register field values other than 0x0000000B / 0x0000000C where a register is required are illegal.
REQ-021 SHALL: dec_flush empties buffer next cycle (state EMPTY, dec_valid 0); flush with simultaneous fetch transfer discards the incoming word.
REQ-022 SHALL: outputs remain stable while dec_valid && !dec_ready.

Reset
REQ-023 SHALL: on reset: state EMPTY, dec_valid 0, fetch_ready 1, dec_op NOP, dec_reg 00, dec_addr_mode 0, dec_operand 0, dec_illegal 0.
REQ-024 SHALL: reset mid-transfer discards all buffered words; first post-reset accept is the next fetch_valid word.

Configuration
REQ-025 SHALL: macro DECODE_ILLEGAL_TRAP_EN defined: illegal words are presented with dec_op NOP and dec_illegal 1, and hold a sticky internal trap flag until reset.
REQ-026 SHALL: macro absent: illegal words are accepted and silently dropped (never presented); dec_illegal tied 0.

Structure
REQ-027 SHALL: package decode_pkg holds opcode constants, dec_op enum, register codes (REG_B = 0xB, REG_C = 0xC), and the decoded-word struct.
REQ-028 SHALL: combinational sub-module inst_decoder maps 68-bit word to decoded struct; decode_stage owns buffer and FSM.

Verification
REQ-029 SHALL: reset, send 0x9_00000000_00000003 (LDA 0x03), dec_ready=1 -> next cycle dec_valid=1, dec_op=LDA, dec_addr_mode=1, dec_operand=0x3, dec_reg=00.
REQ-030 SHALL: send 0xD_0000000B_00000004 (MOV B,0x04) -> dec_op=MOV, dec_reg=01, dec_operand=0x4.
REQ-031 SHALL: dec_ready=0, stream 3 words back-to-back -> fetch_ready falls after second accept; release dec_ready -> all 3 emerge in order, none lost.
REQ-032 SHALL: send opcode 111 word -> trap build: dec_illegal=1, dec_op=NOP; non-trap build: no dec_valid pulse.
REQ-033 SHALL: buffer in TWO, assert dec_flush with fetch_valid=1 -> next cycle dec_valid=0, fetch_ready=1, incoming word never presented.
REQ-034 SHALL: assert reset asynchronously while state ONE -> dec_valid drops without a clock edge; REQ-023 values hold.
